poli_apb_arbiter: RTL and testbench



---
 rtl/POLI_types_pkg.sv | 29 ++
 rtl/poli_rr_select.sv | 37 +++
 rtl/poli_apb_arbiter.sv | 136 +++++++++++++
 tb/tb_poli_apb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/POLI_types_pkg.sv
// POLI_types_pkg: shared types and constants for the POLI system.
// Holds the bus word width, the peripheral register map and the
// APB arbiter state type and default parameters.
package POLI_types_pkg;

  localparam int WORD_SIZE = 32;

  // Peripheral register map
  localparam logic [WORD_SIZE-1:0] CRC_CONFIG_ADDR      = 32'h0000_0100;
  localparam logic [WORD_SIZE-1:0] CRC_INPUT_ADDR       = 32'h0000_0104;
  localparam logic [WORD_SIZE-1:0] CRC_OUTPUT_ADDR      = 32'h0000_0108;
  localparam logic [WORD_SIZE-1:0] NAND_NOR_CONFIG_ADDR = 32'h0000_0200;
  localparam logic [WORD_SIZE-1:0] NAND_NOR_INPUT_ADDR  = 32'h0000_0204;
  localparam logic [WORD_SIZE-1:0] NAND_NOR_OUTPUT_ADDR = 32'h0000_0208;
  localparam logic [WORD_SIZE-1:0] XOR_BUF_CONFIG_ADDR  = 32'h0000_0300;
  localparam logic [WORD_SIZE-1:0] XOR_BUF_INPUT_ADDR   = 32'h0000_0304;
  localparam logic [WORD_SIZE-1:0] XOR_BUF_OUTPUT_ADDR  = 32'h0000_0308;

  // APB arbiter
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_t;

  localparam int NUM_APB_REQ = 4;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/poli_rr_select.sv
// poli_rr_select: combinational round-robin picker.
// Searches the eligible mask starting at the pointer, ascending index,
// wrapping NUM_REQ-1 -> 0, and returns the first set index.
//   i_eligible  in   NUM_REQ  requesters that may be granted
//   i_ptr       in   IDX_W    highest-priority index this round
//   o_winner    out  IDX_W    selected index (0 when none)
//   o_valid     out  1        at least one eligible requester
module poli_rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  // Walk offsets from farthest to nearest so the entry closest to the
  // pointer is assigned last and therefore wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop; a path that
    // leaves one unassigned would infer a latch.
    o_winner = '0;
    o_valid  = 1'b0;
    idx      = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(i_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_eligible[IDX_W'(idx)]) begin
        o_winner = IDX_W'(idx);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/poli_apb_arbiter.sv
// poli_apb_arbiter: shares one APB master port among NUM_REQ requesters.
// Each requester posts one word transaction; winners are chosen
// round-robin and run a full SETUP/ACCESS cycle. Completion returns a
// one-cycle done pulse to the winner with err (timeout) and rdata.
//   CLK, nRST          clock, async active-low reset
//   req/req_write      per-requester request level and direction
//   req_addr/req_wdata packed per-requester address / write data
//   done/err/rdata     completion pulse (one-hot), timeout flag, read data
//   busy               transfer in progress
//   PADDR..PENABLE     APB master outputs; PRDATA/PREADY APB inputs
module poli_apb_arbiter #(
  parameter int NUM_REQ   = POLI_types_pkg::NUM_APB_REQ,
  parameter int TIMEOUT   = POLI_types_pkg::APB_TIMEOUT,
  parameter int WORD_SIZE = POLI_types_pkg::WORD_SIZE
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic [WORD_SIZE-1:0]         rdata,
  output logic                         busy,
  output logic [WORD_SIZE-1:0]         PADDR,
  output logic [WORD_SIZE-1:0]         PWDATA,
  output logic                         PWRITE,
  output logic                         PSEL,
  output logic                         PENABLE,
  input  logic [WORD_SIZE-1:0]         PRDATA,
  input  logic                         PREADY
);

  import POLI_types_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  apb_arb_state_t         r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_write;
  logic [WORD_SIZE-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   r_rdata;
  logic [NUM_REQ-1:0]     r_done;
  logic                   r_err;

  logic [NUM_REQ-1:0]     w_eligible;
  logic [IDX_W-1:0]       w_winner;
  logic                   w_valid;
  logic                   w_timeout;

  // The requester being completed this cycle still shows req high; mask
  // it so a held req is only re-granted after the others had a turn.
  assign w_eligible = req & ~r_done;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  poli_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_winner   (w_winner),
    .o_valid    (w_valid)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_idx   <= w_winner;
            r_write <= req_write[w_winner];
            r_addr  <= req_addr[int'(w_winner)*WORD_SIZE +: WORD_SIZE];
            // Reads drive PWDATA low, so only a write latches its data.
            r_wdata <= req_write[w_winner] ?
                       req_wdata[int'(w_winner)*WORD_SIZE +: WORD_SIZE] : '0;
            r_ptr   <= (w_winner == IDX_LAST) ? '0 : w_winner + 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cnt   <= '0;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            r_state <= IDLE;
            r_done  <= NUM_REQ'(1) << r_idx;
            r_rdata <= r_write ? '0 : PRDATA;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_done  <= NUM_REQ'(1) << r_idx;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // APB outputs come only from registered state and latched fields;
  // gating by busy keeps them all zero in IDLE.
  assign busy    = (r_state != IDLE);
  assign PSEL    = busy;
  assign PENABLE = (r_state == ACCESS);
  assign PADDR   = busy ? r_addr : '0;
  assign PWDATA  = busy ? r_wdata : '0;
  assign PWRITE  = busy & r_write;

  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_poli_apb_arbiter.sv
// Self-checking bench for poli_apb_arbiter: requester models, an APB
// slave with programmable wait states, and a scoreboard of expected
// completions checked whenever done pulses.
module tb_poli_apb_arbiter;
  import POLI_types_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic            CLK;
  logic            nRST;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_write;
  logic [NR*W-1:0] req_addr;
  logic [NR*W-1:0] req_wdata;
  logic [NR-1:0]   done;
  logic            err;
  logic [W-1:0]    rdata;
  logic            busy;
  logic [W-1:0]    PADDR;
  logic [W-1:0]    PWDATA;
  logic            PWRITE;
  logic            PSEL;
  logic            PENABLE;
  logic [W-1:0]    PRDATA;
  logic            PREADY;

  poli_apb_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .WORD_SIZE(W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic       err;
    logic [W-1:0] rdata;
    int         acc_len;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_done(input int idx, input logic e, input logic [W-1:0] rd, input int acc);
    exp_t x;
    x.idx = idx; x.err = e; x.rdata = rd; x.acc_len = acc;
    sb_q.push_back(x);
  endtask

  // Requester models: rq_rem[i] = transfers still to be issued.
  int           rq_rem   [NR];
  logic         rq_write [NR];
  logic [W-1:0] rq_addr  [NR];
  logic [W-1:0] rq_wdata [NR];

  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      req[i]              = (rq_rem[i] > 0);
      req_write[i]        = rq_write[i];
      req_addr[i*W +: W]  = rq_addr[i];
      req_wdata[i*W +: W] = rq_wdata[i];
    end
  end

  // APB slave: ready after sl_wait wait states unless stuck.
  int           sl_wait;
  logic         sl_stuck;
  logic [W-1:0] sl_rdata;
  int           acc_n;

  always @(posedge CLK) begin
    #2;
    if (nRST && PSEL && PENABLE) acc_n++;
    else acc_n = 0;
    PREADY = nRST && PSEL && PENABLE && !sl_stuck && (acc_n > sl_wait);
    PRDATA = PREADY ? sl_rdata : 32'hBAD0_BAD0;
  end

  // Monitor / scoreboard
  int cyc = 0;
  int acc_run = 0;
  int done_t[$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    exp_t e;
    if (!nRST) begin
      acc_run = 0;
    end else begin
      if (PSEL && !PENABLE) acc_run = 0;
      else if (PSEL && PENABLE) acc_run++;
      if (done != 0) begin
        done_t.push_back(cyc);
        for (int i = 0; i < NR; i++)
          if (done[i] && rq_rem[i] > 0) rq_rem[i]--;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", done, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_done", done, 64'(NR'(1) << e.idx));
          check("sb_err", err, e.err);
          check("sb_rdata", rdata, e.rdata);
          check("sb_access_len", acc_run, e.acc_len);
        end
      end
    end
  end

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, sb_q.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_psel"}, PSEL, 0);
    check({tag, "_penable"}, PENABLE, 0);
    check({tag, "_paddr"}, PADDR, 0);
    check({tag, "_pwdata"}, PWDATA, 0);
    check({tag, "_pwrite"}, PWRITE, 0);
  endtask

  task automatic wait_access(input string tag, input int budget);
    int n = 0;
    while (!(PSEL && PENABLE) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, PSEL && PENABLE, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      rq_rem[i] = 0; rq_write[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0;
    end
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    sl_wait = 0; sl_stuck = 1'b0; sl_rdata = '0; acc_n = 0;
    PREADY = 1'b0; PRDATA = '0;
    nRST = 1'b1;
    #3 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    check_zero("reset");
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Round-robin fairness: all four request, requester 0 twice.
    for (int i = 0; i < NR; i++) begin
      rq_write[i] = 1'b1;
      rq_addr[i]  = XOR_BUF_INPUT_ADDR;
      rq_wdata[i] = 32'h1000_0000 + i;
      rq_rem[i]   = (i == 0) ? 2 : 1;
    end
    expect_done(0, 1'b0, '0, 1);
    expect_done(1, 1'b0, '0, 1);
    expect_done(2, 1'b0, '0, 1);
    expect_done(3, 1'b0, '0, 1);
    expect_done(0, 1'b0, '0, 1);
    done_t.delete();
    drain("rr_drain", 60);
    check("rr_count", done_t.size(), 5);
    for (int k = 1; k < done_t.size(); k++)
      check("rr_gap", done_t[k] - done_t[k-1], 3);

    // Single write by requester 1 (pointer is now 1).
    rq_write[1] = 1'b1; rq_addr[1] = CRC_CONFIG_ADDR; rq_wdata[1] = 32'hDEADBEEF;
    rq_rem[1] = 1;
    expect_done(1, 1'b0, '0, 1);
    @(negedge CLK);
    check("wr_t_phase", {PSEL, PENABLE}, 2'b00);
    @(negedge CLK);
    check("wr_setup_phase", {PSEL, PENABLE}, 2'b10);
    check("wr_setup_paddr", PADDR, CRC_CONFIG_ADDR);
    check("wr_setup_pwrite", PWRITE, 1);
    check("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
    @(negedge CLK);
    check("wr_access_phase", {PSEL, PENABLE}, 2'b11);
    check("wr_access_paddr", PADDR, CRC_CONFIG_ADDR);
    @(negedge CLK);
    check("wr_done", done, 4'b0010);
    check("wr_err", err, 0);
    check("wr_rdata", rdata, 0);
    check("wr_done_psel", PSEL, 0);
    drain("wr_drain", 10);

    // Single read by requester 2 with 3 wait states.
    sl_wait = 3; sl_rdata = 32'h1234ABCD;
    rq_write[2] = 1'b0; rq_addr[2] = CRC_OUTPUT_ADDR; rq_wdata[2] = 32'hFFFF_0000;
    rq_rem[2] = 1;
    expect_done(2, 1'b0, 32'h1234ABCD, 4);
    wait_access("rd_access_seen", 10);
    check("rd_paddr", PADDR, CRC_OUTPUT_ADDR);
    check("rd_pwrite", PWRITE, 0);
    check("rd_pwdata", PWDATA, 0);
    drain("rd_drain", 20);
    sl_wait = 0;

    // Timeout: requester 1 read, slave never ready; rdata was non-zero.
    sl_stuck = 1'b1;
    rq_write[1] = 1'b0; rq_addr[1] = NAND_NOR_OUTPUT_ADDR; rq_rem[1] = 1;
    expect_done(1, 1'b1, '0, TO);
    begin
      int n = 0;
      while (done == 0 && n < 40) begin
        @(negedge CLK);
        n++;
      end
    end
    check("to_done", done, 4'b0010);
    check("to_err", err, 1);
    check("to_psel", PSEL, 0);
    sl_stuck = 1'b0;
    drain("to_drain", 10);
    sl_rdata = 32'hCAFE_0042;
    rq_write[2] = 1'b0; rq_addr[2] = XOR_BUF_OUTPUT_ADDR; rq_rem[2] = 1;
    expect_done(2, 1'b0, 32'hCAFE_0042, 1);
    drain("to_next_drain", 20);

    // Masking and wrap: pointer is 3, requesters 3 (twice) and 0.
    rq_write[3] = 1'b1; rq_addr[3] = NAND_NOR_CONFIG_ADDR; rq_wdata[3] = 32'h0000_0033;
    rq_write[0] = 1'b1; rq_addr[0] = NAND_NOR_INPUT_ADDR;  rq_wdata[0] = 32'h0000_0000;
    rq_rem[3] = 2; rq_rem[0] = 1;
    expect_done(3, 1'b0, '0, 1);
    expect_done(0, 1'b0, '0, 1);
    expect_done(3, 1'b0, '0, 1);
    drain("wrap_drain", 30);

    // Read by requester 1 so pointer = 2 and rdata is non-zero.
    sl_rdata = 32'h5A5A_1111;
    rq_write[1] = 1'b0; rq_addr[1] = CRC_INPUT_ADDR; rq_rem[1] = 1;
    expect_done(1, 1'b0, 32'h5A5A_1111, 1);
    drain("pre_rst_drain", 20);

    // Reset mid-ACCESS: requesters 1 and 3, pointer 2 grants 3 first.
    sl_stuck = 1'b1;
    rq_write[1] = 1'b1; rq_addr[1] = CRC_CONFIG_ADDR;     rq_wdata[1] = 32'h0000_0011;
    rq_write[3] = 1'b1; rq_addr[3] = XOR_BUF_CONFIG_ADDR; rq_wdata[3] = 32'h0000_0033;
    rq_rem[1] = 1; rq_rem[3] = 1;
    wait_access("rst_access_seen", 10);
    check("rst_pre_paddr", PADDR, XOR_BUF_CONFIG_ADDR);
    #2 nRST = 1'b0;
    #1 check_zero("rst_async");
    sl_stuck = 1'b0;
    @(negedge CLK);
    check("rst_hold_done", done, 0);
    expect_done(1, 1'b0, '0, 1);
    expect_done(3, 1'b0, '0, 1);
    nRST = 1'b1;
    drain("rst_drain", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
